// File: rtl/wbvidcapture.sv
// wbvidcapture -- raster video capture into a word-per-pixel frame buffer.
//
// Accepts a SOF/EOL framed pixel stream (one pixel per valid cycle, no
// backpressure).  Each stored pixel becomes one Wishbone pipelined write of
// {zeros, pixel} at i_base_addr + row*i_line_words + col.  Pixels beyond
// i_width on a line are cropped.  Writes queue in a 2**LGFIFO entry FIFO.
//
// Ports
//   i_clk, i_reset_n           clock, asynchronous active-low reset
//   i_en                       capture enable
//   i_base_addr                word address of line 0, pixel 0
//   i_line_words               line stride in words
//   i_width, i_height          stored pixels per line, lines per frame
//   i_pix_valid/sof/eol/data   pixel stream ({red,grn,blu})
//   o_wb_*                     Wishbone pipelined master (write only)
//   i_wb_stall/ack/err         Wishbone slave responses
//   o_busy                     engine not idle
//   o_overflow                 sticky: pixel dropped on full FIFO
//   o_err                      bus error seen (held while in error state)
//   o_interrupt                one-cycle pulse: frame fully committed
`timescale 1ns/1ps
module wbvidcapture #(
    parameter int ADDRESS_WIDTH  = 24,
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BITS_PER_COLOR = 8,
    parameter int FW             = 13,
    parameter int LW             = 12,
    parameter int LGFIFO         = 5
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_en,
    input  logic [ADDRESS_WIDTH-1:0]    i_base_addr,
    input  logic [FW:0]                 i_line_words,
    input  logic [FW-1:0]               i_width,
    input  logic [LW-1:0]               i_height,
    input  logic                        i_pix_valid,
    input  logic                        i_pix_sof,
    input  logic                        i_pix_eol,
    input  logic [3*BITS_PER_COLOR-1:0] i_pix_data,
    output logic                        o_wb_cyc,
    output logic                        o_wb_stb,
    output logic                        o_wb_we,
    output logic [ADDRESS_WIDTH-1:0]    o_wb_addr,
    output logic [BUS_DATA_WIDTH-1:0]   o_wb_data,
    output logic [BUS_DATA_WIDTH/8-1:0] o_wb_sel,
    input  logic                        i_wb_stall,
    input  logic                        i_wb_ack,
    input  logic                        i_wb_err,
    output logic                        o_busy,
    output logic                        o_overflow,
    output logic                        o_err,
    output logic                        o_interrupt
);

    localparam int AW    = ADDRESS_WIDTH;
    localparam int DW    = BUS_DATA_WIDTH;
    localparam int PW    = 3 * BITS_PER_COLOR;
    localparam int DEPTH = 1 << LGFIFO;
    localparam int OW    = LGFIFO + 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_CAPTURE,
        S_DRAIN,
        S_ERROR
    } state_t;

    state_t state, state_next;

    logic [AW-1:0]     fifo_addr [DEPTH];
    logic [PW-1:0]     fifo_pix  [DEPTH];
    logic [LGFIFO-1:0] wr_ptr, rd_ptr;
    logic [LGFIFO:0]   count;
    logic [OW-1:0]     outstanding;

    logic [FW-1:0]     col;
    logic [LW-1:0]     row;
    logic [AW-1:0]     line_addr;
    logic              overflow;
    logic              no_irq;      // current drain was an abort, not a frame end

    logic              fifo_empty, fifo_full;
    logic              accepting, take_sof, take_mid;
    logic              push_req, push, pop;
    logic [AW-1:0]     push_addr;
    logic [LW-1:0]     row_eff;
    logic              last_line, frame_end;
    logic              stb, cyc, bus_err, drained;

    // Capture decode and bus handshake
    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = count[LGFIFO];
        accepting  = i_en && i_pix_valid &&
                     (state == S_WAIT_SOF || state == S_CAPTURE);
        take_sof   = accepting && i_pix_sof;
        take_mid   = accepting && !i_pix_sof && (state == S_CAPTURE);
        push_req   = take_sof || (take_mid && (col < i_width));
        push       = push_req && !fifo_full;
        push_addr  = take_sof ? i_base_addr : line_addr + AW'(col);
        // a SOF pixel is on row 0 regardless of the aborted frame's row
        row_eff    = take_sof ? '0 : row;
        last_line  = (row_eff == i_height - LW'(1));
        frame_end  = (take_sof || take_mid) && i_pix_eol && last_line;
        stb        = !fifo_empty && (state != S_ERROR);
        cyc        = stb || (outstanding != '0);
        pop        = stb && !i_wb_stall;
        bus_err    = i_wb_err && cyc;
        drained    = fifo_empty && (outstanding == '0);
    end

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        if (bus_err) begin
            state_next = S_ERROR;
        end else begin
            case (state)
                S_IDLE:     if (i_en) state_next = S_WAIT_SOF;
                S_WAIT_SOF: begin
                    if (!i_en || frame_end) state_next = S_DRAIN;
                    else if (take_sof)      state_next = S_CAPTURE;
                end
                S_CAPTURE:  if (!i_en || frame_end) state_next = S_DRAIN;
                S_DRAIN:    if (drained)
                                state_next = (!no_irq && i_en) ? S_WAIT_SOF : S_IDLE;
                S_ERROR:    if (!i_en) state_next = S_IDLE;
                default:    state_next = S_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        o_busy      = (state != S_IDLE);
        o_err       = (state == S_ERROR);
        o_interrupt = (state == S_DRAIN) && drained && !no_irq;
    end

    // FIFO pointers and outstanding-ack counter
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
        end else if (bus_err) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + LGFIFO'(1);
            if (pop)  rd_ptr <= rd_ptr + LGFIFO'(1);
            case ({push, pop})
                2'b10:   count <= count + (LGFIFO+1)'(1);
                2'b01:   count <= count - (LGFIFO+1)'(1);
                default: count <= count;
            endcase
            case ({pop, i_wb_ack})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   if (outstanding != '0) outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= push_addr;
            fifo_pix[wr_ptr]  <= i_pix_data;
        end
    end

    // Raster position tracking
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            col       <= '0;
            row       <= '0;
            line_addr <= '0;
            overflow  <= 1'b0;
            no_irq    <= 1'b0;
        end else begin
            if (take_sof || take_mid) begin
                if (take_sof)
                    overflow <= fifo_full;
                else if (push_req && fifo_full)
                    overflow <= 1'b1;
                if (i_pix_eol) begin
                    col       <= '0;
                    row       <= row_eff + LW'(1);
                    line_addr <= (take_sof ? i_base_addr : line_addr) + AW'(i_line_words);
                end else if (take_sof) begin
                    col       <= FW'(1);
                    row       <= '0;
                    line_addr <= i_base_addr;
                end else if (col != '1) begin
                    col <= col + FW'(1);
                end
            end
            if (state == S_WAIT_SOF || state == S_CAPTURE) begin
                if (!i_en)
                    no_irq <= 1'b1;
                else if (frame_end)
                    no_irq <= 1'b0;
            end
        end
    end

    always_comb begin
        o_wb_cyc   = cyc;
        o_wb_stb   = stb;
        o_wb_we    = 1'b1;
        o_wb_sel   = '1;
        o_wb_addr  = fifo_addr[rd_ptr];
        o_wb_data  = DW'(fifo_pix[rd_ptr]);
        o_overflow = overflow;
    end

endmodule

// File: tb/tb_wbvidcapture.sv
`timescale 1ns/1ps
module tb_wbvidcapture;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_en;
    logic [23:0] i_base_addr;
    logic [13:0] i_line_words;
    logic [12:0] i_width;
    logic [11:0] i_height;
    logic        i_pix_valid, i_pix_sof, i_pix_eol;
    logic [23:0] i_pix_data;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [23:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_stall, i_wb_ack, i_wb_err;
    logic        o_busy, o_overflow, o_err, o_interrupt;

    wbvidcapture #(
        .ADDRESS_WIDTH(24), .BUS_DATA_WIDTH(32), .BITS_PER_COLOR(8),
        .FW(13), .LW(12), .LGFIFO(5)
    ) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_en(i_en),
        .i_base_addr(i_base_addr), .i_line_words(i_line_words),
        .i_width(i_width), .i_height(i_height),
        .i_pix_valid(i_pix_valid), .i_pix_sof(i_pix_sof),
        .i_pix_eol(i_pix_eol), .i_pix_data(i_pix_data),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .o_busy(o_busy), .o_overflow(o_overflow), .o_err(o_err),
        .o_interrupt(o_interrupt)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int passed = 0;
    int total  = 0;
    int irq_count = 0;
    int resp_n = 0;
    int err_on = 0;
    logic err_now;
    logic cyc_after_err = 1'b1;
    logic err_after = 1'b0;

    logic [23:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [23:0] exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) begin
            passed = passed + 1;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: bus slave model (accept log, ack one cycle later) + irq count
    task automatic tick();
        logic acc;
        acc = o_wb_stb && !i_wb_stall;
        if (acc) begin
            log_addr.push_back(o_wb_addr);
            log_data.push_back(o_wb_data);
        end
        if (o_interrupt) irq_count = irq_count + 1;
        err_now = i_wb_err;
        @(posedge i_clk);
        #1;
        if (err_now) begin
            cyc_after_err = o_wb_cyc;
            err_after     = o_err;
        end
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        if (acc) begin
            resp_n = resp_n + 1;
            if (resp_n == err_on) i_wb_err = 1'b1;
            else                  i_wb_ack = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pix(input logic [23:0] d, input logic sof, input logic eol);
        i_pix_valid = 1'b1;
        i_pix_data  = d;
        i_pix_sof   = sof;
        i_pix_eol   = eol;
        tick();
        i_pix_valid = 1'b0;
        i_pix_sof   = 1'b0;
        i_pix_eol   = 1'b0;
    endtask

    task automatic send_line(input int n, input logic sof, input logic [7:0] tag, input int start);
        for (int i = 0; i < n; i++)
            pix({tag, 16'(start + i)}, sof && (i == 0), i == n - 1);
    endtask

    task automatic expect_run(input logic [23:0] addr0, input logic [7:0] tag,
                              input int start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(addr0 + 24'(i));
            exp_data.push_back({8'h00, tag, 16'(start + i)});
        end
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_data.delete();
        exp_addr.delete();
        exp_data.delete();
        irq_count = 0;
    endtask

    task automatic verify(input string tag);
        logic [23:0] a;
        logic [31:0] d;
        check({tag, " count"}, 64'(log_addr.size()), 64'(exp_addr.size()));
        for (int k = 0; k < exp_addr.size(); k++) begin
            a = (k < log_addr.size()) ? log_addr[k] : 24'hFFFFFF;
            d = (k < log_data.size()) ? log_data[k] : 32'hFFFFFFFF;
            check($sformatf("%s addr[%0d]", tag, k), 64'(a), 64'(exp_addr[k]));
            check($sformatf("%s data[%0d]", tag, k), 64'(d), 64'(exp_data[k]));
        end
    endtask

    initial begin
        i_reset_n = 1'b0; i_en = 1'b0;
        i_base_addr = 24'h001000; i_line_words = 14'd640;
        i_width = 13'd4; i_height = 12'd2;
        i_pix_valid = 1'b0; i_pix_sof = 1'b0; i_pix_eol = 1'b0; i_pix_data = '0;
        i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
        idle(3);
        check("rst cyc",  64'(o_wb_cyc),    64'(0));
        check("rst stb",  64'(o_wb_stb),    64'(0));
        check("rst busy", 64'(o_busy),      64'(0));
        check("rst ovf",  64'(o_overflow),  64'(0));
        check("rst err",  64'(o_err),       64'(0));
        check("rst irq",  64'(o_interrupt), 64'(0));
        i_reset_n = 1'b1;
        idle(2);
        check("idle busy", 64'(o_busy), 64'(0));

        // 1: two 4-pixel lines, no stall
        clear_logs();
        i_en = 1'b1;
        tick();
        check("t1 busy", 64'(o_busy), 64'(1));
        send_line(4, 1'b1, 8'h01, 0);
        send_line(4, 1'b0, 8'h01, 4);
        idle(15);
        expect_run(24'h001000, 8'h01, 0, 4);
        expect_run(24'h001280, 8'h01, 4, 4);
        verify("t1");
        check("t1 irq", 64'(irq_count), 64'(1));
        check("t1 cyc", 64'(o_wb_cyc), 64'(0));
        check("t1 sel", 64'(o_wb_sel), 64'(4'hF));
        check("t1 we",  64'(o_wb_we),  64'(1));

        // 2: stall held 20 cycles mid-frame
        clear_logs();
        pix({8'h02, 16'd0}, 1'b1, 1'b0);
        pix({8'h02, 16'd1}, 1'b0, 1'b0);
        i_wb_stall = 1'b1;
        pix({8'h02, 16'd2}, 1'b0, 1'b0);
        pix({8'h02, 16'd3}, 1'b0, 1'b1);
        send_line(4, 1'b0, 8'h02, 4);
        idle(14);
        check("t2 cyc stalled", 64'(o_wb_cyc), 64'(1));
        i_wb_stall = 1'b0;
        idle(20);
        expect_run(24'h001000, 8'h02, 0, 4);
        expect_run(24'h001280, 8'h02, 4, 4);
        verify("t2");
        check("t2 ovf", 64'(o_overflow), 64'(0));
        check("t2 irq", 64'(irq_count), 64'(1));
        check("t2 cyc", 64'(o_wb_cyc), 64'(0));

        // 3: 6-pixel lines cropped to width 4
        clear_logs();
        send_line(6, 1'b1, 8'h03, 0);
        send_line(6, 1'b0, 8'h03, 6);
        idle(15);
        expect_run(24'h001000, 8'h03, 0, 4);
        expect_run(24'h001280, 8'h03, 6, 4);
        verify("t3");
        check("t3 irq", 64'(irq_count), 64'(1));

        // 4: 40 pixels under a 64-cycle stall overflow the 32-entry FIFO
        clear_logs();
        i_width = 13'd20;
        i_wb_stall = 1'b1;
        send_line(20, 1'b1, 8'h04, 0);
        send_line(20, 1'b0, 8'h04, 20);
        idle(24);
        check("t4 ovf stalled", 64'(o_overflow), 64'(1));
        check("t4 no writes", 64'(log_addr.size()), 64'(0));
        i_wb_stall = 1'b0;
        idle(50);
        expect_run(24'h001000, 8'h04, 0, 20);
        expect_run(24'h001280, 8'h04, 20, 12);
        verify("t4");
        check("t4 ovf sticky", 64'(o_overflow), 64'(1));
        check("t4 irq", 64'(irq_count), 64'(1));
        i_width = 13'd4;

        // 5: bus error on the third response
        clear_logs();
        resp_n = 0;
        err_on = 3;
        send_line(4, 1'b1, 8'h05, 0);
        send_line(4, 1'b0, 8'h05, 4);
        idle(5);
        check("t5 cyc after err", 64'(cyc_after_err), 64'(0));
        check("t5 err after err", 64'(err_after), 64'(1));
        check("t5 err held", 64'(o_err), 64'(1));
        check("t5 cyc", 64'(o_wb_cyc), 64'(0));
        check("t5 busy", 64'(o_busy), 64'(1));
        check("t5 ovf cleared", 64'(o_overflow), 64'(0));
        check("t5 irq", 64'(irq_count), 64'(0));
        i_en = 1'b0;
        tick();
        check("t5 err cleared", 64'(o_err), 64'(0));
        check("t5 idle", 64'(o_busy), 64'(0));
        err_on = 0;
        i_en = 1'b1;
        tick();
        clear_logs();
        send_line(4, 1'b1, 8'h06, 0);
        send_line(4, 1'b0, 8'h06, 4);
        idle(15);
        expect_run(24'h001000, 8'h06, 0, 4);
        expect_run(24'h001280, 8'h06, 4, 4);
        verify("t5b");
        check("t5b irq", 64'(irq_count), 64'(1));
        check("t5b err", 64'(o_err), 64'(0));

        // 6: SOF mid-line 1 restarts the frame at base
        clear_logs();
        send_line(4, 1'b1, 8'h07, 0);
        pix({8'h07, 16'd4}, 1'b0, 1'b0);
        pix({8'h07, 16'd5}, 1'b0, 1'b0);
        send_line(4, 1'b1, 8'h07, 16);
        send_line(4, 1'b0, 8'h07, 20);
        idle(15);
        expect_run(24'h001000, 8'h07, 0, 4);
        expect_run(24'h001280, 8'h07, 4, 2);
        expect_run(24'h001000, 8'h07, 16, 4);
        expect_run(24'h001280, 8'h07, 20, 4);
        verify("t6");
        check("t6 irq", 64'(irq_count), 64'(1));

        // async reset while a write is strobed
        i_wb_stall = 1'b1;
        pix({8'h08, 16'd0}, 1'b1, 1'b0);
        pix({8'h08, 16'd1}, 1'b0, 1'b0);
        check("ar stb before", 64'(o_wb_stb), 64'(1));
        #2;
        i_reset_n = 1'b0;
        #1;
        check("ar cyc",  64'(o_wb_cyc),    64'(0));
        check("ar stb",  64'(o_wb_stb),    64'(0));
        check("ar busy", 64'(o_busy),      64'(0));
        check("ar ovf",  64'(o_overflow),  64'(0));
        check("ar err",  64'(o_err),       64'(0));
        check("ar irq",  64'(o_interrupt), 64'(0));
        i_wb_stall = 1'b0;
        i_en = 1'b0;
        idle(2);
        i_reset_n = 1'b1;
        idle(2);
        check("ar idle", 64'(o_busy), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
